// File: rtl/rgb_pwm.sv
// -----------------------------------------------------------------------------
// rgb_pwm - three-channel PWM generator for the RGB LED IP.
//
// Uses the upstream free-running counter value (cnt) as the PWM timebase and
// compares it against per-channel active duty registers. New duties arrive on
// a valid/ready handshake, are held in a pending buffer and only take effect
// at a period boundary (cnt == 0), so a PWM period is never torn.
//
// Optional feature macro: RGB_PWM_FADE_EN
//   undefined : the pending duty is applied in one step at the next boundary.
//   defined   : the pending duty is a target; each active duty steps +/-1
//               toward it once per boundary until all three channels match.
//
// Parameters:
//   W          PWM resolution in bits (equals upstream counter width)
//   ACTIVE_LOW 1 inverts the LED outputs (common-anode parts)
//
// Ports:
//   clk                     clock
//   rst                     synchronous active-high reset
//   cnt[W-1:0]              timebase from the upstream up_counter
//   duty_r/g/b[W-1:0]       requested duty per channel, in counts
//   duty_valid              request holds new duty values
//   duty_ready              block can accept a request (decode of state)
//   led_r/g/b               registered PWM outputs
//   period_start            one-cycle pulse the cycle after cnt == 0
//   duty_applied            one-cycle pulse the cycle after new duties settle
// -----------------------------------------------------------------------------
module rgb_pwm #(
  parameter int unsigned W          = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] duty_r,
  input  logic [W-1:0] duty_g,
  input  logic [W-1:0] duty_b,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         led_r,
  output logic         led_g,
  output logic         led_b,
  output logic         period_start,
  output logic         duty_applied
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};

`ifdef RGB_PWM_FADE_EN
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FADING = 1'b1} state_t;
  localparam state_t ST_BUSY = ST_FADING;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Move one count toward the target; hold once equal.
  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt);
    logic [W-1:0] res;
    if (cur < tgt) begin
      res = cur + ONE;
    end else if (cur > tgt) begin
      res = cur - ONE;
    end else begin
      res = cur;
    end
    return res;
  endfunction
`else
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;
  localparam state_t ST_BUSY = ST_PENDING;
`endif

  state_t       state_r;
  logic [W-1:0] pend_red_r, pend_grn_r, pend_blu_r;
  logic [W-1:0] act_red_r,  act_grn_r,  act_blu_r;
  logic [W-1:0] nxt_red_s,  nxt_grn_s,  nxt_blu_s;
  logic [W-1:0] eff_red_s,  eff_grn_s,  eff_blu_s;
  logic         boundary_s;
  logic         done_s;
  logic         update_s;

  assign duty_ready = (state_r == ST_IDLE);

  // Boundary detect, next active duties and the compare values for this cycle.
  always_comb begin
    boundary_s = (cnt == ZERO);
    update_s   = boundary_s && (state_r == ST_BUSY);
`ifdef RGB_PWM_FADE_EN
    nxt_red_s  = step_toward(act_red_r, pend_red_r);
    nxt_grn_s  = step_toward(act_grn_r, pend_grn_r);
    nxt_blu_s  = step_toward(act_blu_r, pend_blu_r);
    done_s     = (nxt_red_s == pend_red_r) && (nxt_grn_s == pend_grn_r) &&
                 (nxt_blu_s == pend_blu_r);
`else
    nxt_red_s  = pend_red_r;
    nxt_grn_s  = pend_grn_r;
    nxt_blu_s  = pend_blu_r;
    done_s     = 1'b1;
`endif
    // The updated duty already governs the cnt == 0 slot of the new period.
    if (update_s) begin
      eff_red_s = nxt_red_s;
      eff_grn_s = nxt_grn_s;
      eff_blu_s = nxt_blu_s;
    end else begin
      eff_red_s = act_red_r;
      eff_grn_s = act_grn_r;
      eff_blu_s = act_blu_r;
    end
  end

  // Handshake/update state machine, duty registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pend_red_r   <= ZERO;
      pend_grn_r   <= ZERO;
      pend_blu_r   <= ZERO;
      act_red_r    <= ZERO;
      act_grn_r    <= ZERO;
      act_blu_r    <= ZERO;
      led_r        <= ACTIVE_LOW;
      led_g        <= ACTIVE_LOW;
      led_b        <= ACTIVE_LOW;
      period_start <= 1'b0;
      duty_applied <= 1'b0;
    end else begin
      led_r        <= (cnt < eff_red_s) ^ ACTIVE_LOW;
      led_g        <= (cnt < eff_grn_s) ^ ACTIVE_LOW;
      led_b        <= (cnt < eff_blu_s) ^ ACTIVE_LOW;
      period_start <= boundary_s;
      duty_applied <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (duty_valid) begin
            pend_red_r <= duty_r;
            pend_grn_r <= duty_g;
            pend_blu_r <= duty_b;
            state_r    <= ST_BUSY;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (boundary_s) begin
            act_red_r <= nxt_red_s;
            act_grn_r <= nxt_grn_s;
            act_blu_r <= nxt_blu_s;
            if (done_s) begin
              state_r      <= ST_IDLE;
              duty_applied <= 1'b1;
            end else begin
              state_r      <= ST_BUSY;
            end
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_pwm.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm - directed self-checking bench for rgb_pwm (W=8, ACTIVE_LOW=0).
// The bench plays the upstream up_counter itself (with an optional stall) and
// tallies LED on-cycles, pulses and ready over whole periods.
// -----------------------------------------------------------------------------
module tb_rgb_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cnt;
  logic [7:0] duty_r, duty_g, duty_b;
  logic       duty_valid;
  logic       duty_ready;
  logic       led_r, led_g, led_b;
  logic       period_start;
  logic       duty_applied;
  logic       stall;

  int n_checks = 0;
  int n_fail   = 0;

  int m_r, m_g, m_b, m_ap, m_ap_idx, m_ps, m_rdy;

  rgb_pwm #(.W(8), .ACTIVE_LOW(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .cnt          (cnt),
    .duty_r       (duty_r),
    .duty_g       (duty_g),
    .duty_b       (duty_b),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .led_r        (led_r),
    .led_g        (led_g),
    .led_b        (led_b),
    .period_start (period_start),
    .duty_applied (duty_applied)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: the DUT consumes the current cnt, then the counter advances.
  task automatic step();
    @(posedge clk);
    #1;
    if (!stall) cnt = cnt + 8'd1;
  endtask

  // Step until cnt == target is presented to the next edge (bounded).
  task automatic run_to(input logic [7:0] target);
    for (int i = 0; i < 300 && cnt != target; i++) step();
    check_eq("run_to", int'(cnt), int'(target));
  endtask

  // Step n cycles, tallying outputs sampled after each edge.
  task automatic measure(input int n);
    m_r = 0; m_g = 0; m_b = 0; m_ap = 0; m_ap_idx = -1; m_ps = 0; m_rdy = 0;
    for (int i = 0; i < n; i++) begin
      step();
      m_r   += int'(led_r);
      m_g   += int'(led_g);
      m_b   += int'(led_b);
      m_ps  += int'(period_start);
      m_rdy += int'(duty_ready);
      if (duty_applied) begin
        m_ap++;
        if (m_ap_idx < 0) m_ap_idx = i;
      end
    end
  endtask

  task automatic handshake(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    duty_valid = 1'b1;
    duty_r = r; duty_g = g; duty_b = b;
    step();
    duty_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cnt = 8'd0; stall = 1'b0;
    duty_r = 8'd0; duty_g = 8'd0; duty_b = 8'd0; duty_valid = 1'b0;

    // 1. Reset values, then 512 idle cycles.
    step(); step();
    rst = 1'b0;
    check_eq("rst_led_r", int'(led_r), 0);
    check_eq("rst_led_g", int'(led_g), 0);
    check_eq("rst_led_b", int'(led_b), 0);
    check_eq("rst_ready", int'(duty_ready), 1);
    check_eq("rst_pstart", int'(period_start), 0);
    check_eq("rst_applied", int'(duty_applied), 0);
    measure(512);
    check_eq("idle_leds", m_r + m_g + m_b, 0);
    check_eq("idle_applied", m_ap, 0);
    check_eq("idle_ready", m_rdy, 512);
    check_eq("idle_pstart", m_ps, 2);

`ifdef RGB_PWM_FADE_EN
    // 6. Fade 0 -> 3 on red over three periods.
    run_to(8'd100);
    handshake(8'd3, 8'd0, 8'd0);
    check_eq("fade_ready_low", int'(duty_ready), 0);
    run_to(8'd0);
    for (int p = 1; p <= 3; p++) begin
      measure(256);
      check_eq("fade_led_r", m_r, p);
      check_eq("fade_applied", m_ap, (p == 3) ? 1 : 0);
      check_eq("fade_ready", m_rdy, (p == 3) ? 256 : 0);
    end
    check_eq("fade_applied_idx", m_ap_idx, 0);
`else
    // 2. Apply r=64 g=0 b=255 at cnt=100.
    run_to(8'd100);
    handshake(8'd64, 8'd0, 8'd255);
    check_eq("apply_ready_low", int'(duty_ready), 0);
    run_to(8'd0);
    measure(256);
    check_eq("apply_idx", m_ap_idx, 0);
    check_eq("apply_cnt", m_ap, 1);
    check_eq("apply_pstart", m_ps, 1);
    check_eq("apply_led_r", m_r, 64);
    check_eq("apply_led_g", m_g, 0);
    check_eq("apply_led_b", m_b, 255);
    check_eq("apply_ready_back", int'(duty_ready), 1);

    // 3. Back-pressure: r=10 pending, request changes to r=20 while held.
    run_to(8'd50);
    duty_valid = 1'b1; duty_r = 8'd10;
    step();
    check_eq("bp_ready_low", int'(duty_ready), 0);
    run_to(8'd60);
    duty_r = 8'd20;
    run_to(8'd0);
    measure(256);
    check_eq("bp_p1_led_r", m_r, 10);
    check_eq("bp_p1_applied", m_ap, 1);
    check_eq("bp_p1_ready", int'(duty_ready), 0);
    duty_valid = 1'b0;
    measure(256);
    check_eq("bp_p2_led_r", m_r, 20);
    check_eq("bp_p2_applied_idx", m_ap_idx, 0);

    // 4. Handshake in the boundary cycle applies one period later.
    duty_valid = 1'b1; duty_r = 8'd32;
    measure(1);
    duty_valid = 1'b0;
    check_eq("coin_ready_low", int'(duty_ready), 0);
    check_eq("coin_first_led", m_r, 1);
    measure(255);
    check_eq("coin_rest_led_r", m_r, 19);
    check_eq("coin_no_apply", m_ap, 0);
    measure(256);
    check_eq("coin_applied_idx", m_ap_idx, 0);
    check_eq("coin_led_r", m_r, 32);

    // 5. Reset while a request is pending discards it.
    run_to(8'd10);
    handshake(8'd128, 8'd0, 8'd255);
    run_to(8'd200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mrst_ready", int'(duty_ready), 1);
    check_eq("mrst_led_b", int'(led_b), 0);
    run_to(8'd0);
    measure(256);
    check_eq("mrst_led_r", m_r, 0);
    check_eq("mrst_led_b_period", m_b, 0);
    check_eq("mrst_no_apply", m_ap, 0);
    check_eq("mrst_pstart", m_ps, 1);

    // Stalled counter: no boundary, request stays pending.
    run_to(8'd5);
    handshake(8'd77, 8'd0, 8'd0);
    stall = 1'b1;
    measure(300);
    stall = 1'b0;
    check_eq("stall_no_apply", m_ap, 0);
    check_eq("stall_no_pstart", m_ps, 0);
    check_eq("stall_ready", m_rdy, 0);
    run_to(8'd0);
    measure(256);
    check_eq("stall_applied_idx", m_ap_idx, 0);
    check_eq("stall_led_r", m_r, 77);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm.md
# rgb_pwm

Three-channel PWM generator for the RGB LED IP. It sits directly downstream of the free-running `up_counter`: it consumes that counter's value as its timebase and compares it against per-channel duty registers to drive the red, green and blue LED pins. New duty values arrive over a valid/ready handshake and are double-buffered. They take effect only at a PWM period boundary, so a period is never torn.

## Interface

Parameters:
- `W`, 8: PWM resolution in bits; must equal the upstream counter width. Period is 2^W cycles.
- `ACTIVE_LOW`, 0: when 1, LED outputs are inverted (common-anode parts).

Ports:
- `clk`  in  1  clock; the only clock in the block.
- `rst`  in  1  reset; synchronous, active-high.
- `cnt`  in  W  free-running count from the upstream `up_counter`; wraps 2^W−1 → 0.
- `duty_r`, `duty_g`, `duty_b`  in  W each  requested duty per channel, in counts.
- `duty_valid`  in  1  request holds new duty values.
- `duty_ready`  out  1  block can accept a request.
- `led_r`, `led_g`, `led_b`  out  1  PWM outputs.
- `period_start`  out  1  one-cycle pulse, registered, asserted the cycle after `cnt == 0`.
- `duty_applied`  out  1  one-cycle pulse, the cycle after new duties become active.

## Operation

- Registers:
  - `pend_{r,g,b}` holds the accepted request.
  - `act_{r,g,b}` holds the duty currently in use.
- Boundary: any cycle with `cnt == 0`.
- State machine, base build:
  - IDLE: `duty_ready` = 1. On `duty_valid && duty_ready`, capture `duty_*` into `pend_*` and go to PENDING.
  - PENDING: `duty_ready` = 0. On a boundary, `act_*` ← `pend_*`, pulse `duty_applied` next cycle, return to IDLE.
- Compare: `eff_x` = (boundary && state == PENDING) ? `pend_x` : `act_x`. Next `led_x` = (`cnt` < `eff_x`) XOR `ACTIVE_LOW`. The new duty therefore governs the whole period starting at `cnt == 0`.
- Comparison is unsigned, W bits:
  - duty 0 gives an output that is never on.
  - duty 2^W−1 gives an output on for 2^W−1 of 2^W cycles.
  - 100% on is not reachable; this is by design.
- Boundary conditions:
  - Handshake accepted in the same cycle as a boundary: the value goes to `pend_*` and the block enters PENDING. It is applied at the next boundary, 2^W cycles later, not this one.
  - `duty_valid` held high while PENDING: no capture. `duty_*` may change freely; the request is accepted once IDLE returns.
  - `rst` asserted in any state: state ← IDLE. `act_*` and `pend_*` ← 0, discarding any pending request.
  - Upstream counter stalled: no boundary occurs, so PENDING persists indefinitely. There is no timeout.

## Timing

- Reset values:
  - `led_*` = `ACTIVE_LOW`
  - `period_start` = 0
  - `duty_applied` = 0
  - `duty_ready` = 1
- `duty_ready` is a combinational decode of state only; it does not depend on `duty_valid`.
- Latency from `cnt` to `led_*`: 1 cycle, registered.
- Latency from boundary to `duty_applied`: 1 cycle.
- Latency from handshake to `duty_ready` low: next cycle.
- `period_start` and `duty_applied` are coincident when an apply occurs.

## Configuration

- Macro: `RGB_PWM_FADE_EN`.
- Undefined: base behaviour above. `act_*` jumps to `pend_*` at one boundary.
- Defined:
  - `pend_*` is a target. PENDING is replaced by FADING.
  - At each boundary, each `act_x` steps ±1 toward `pend_x` and holds once equal.
  - `eff_x` uses the stepped value at that boundary.
  - The block leaves FADING for IDLE, with a `duty_applied` pulse, on the boundary where all three channels equal their targets.
  - `duty_ready` = 0 throughout FADING.
  - A target equal to `act_*` completes at the first boundary.

## Test plan

All scenarios use W=8, ACTIVE_LOW=0, with `up_counter` driving `cnt`.
1. Reset: `rst` high 2 cycles → `led_*`=0, `duty_ready`=1, `period_start`=0, `duty_applied`=0. All outputs stay 0 for the next 512 cycles.
2. Apply: handshake r=64, g=0, b=255 at `cnt`=100. Required response:
   - `duty_ready`=0 from the next cycle.
   - `duty_applied` one cycle after `cnt`=0.
   - Per 256-cycle period: `led_r` high 64 cycles, `led_g` 0 cycles, `led_b` 255 cycles.
3. Back-pressure: hold `duty_valid`=1 with r=10 in PENDING, then change to r=20 → r=20 is accepted only after `duty_ready` returns. `led_r` shows 20-cycle pulses two boundaries later.
4. Boundary coincidence: handshake r=32 in the cycle `cnt`=0 → no change that period. `duty_applied` fires 256 cycles later, then `led_r` is high 32 cycles per period.
5. Reset mid-operation: handshake r=128, then assert `rst` at `cnt`=200 → after the next boundary, `led_r` stays 0 and `duty_applied` never pulses.
6. `RGB_PWM_FADE_EN`: with `act_r`=0, write r=3 → `led_r` high 1, 2, then 3 cycles in successive periods. `duty_applied` pulses at the third boundary, and `duty_ready`=0 until then.
